// File: rtl/uart_char_sequencer.sv
// Steps the 'A'..'P' character mux into the UART transmitter,
// one byte per tx_start/tx_done handshake, with optional CR/LF trailer.
module uart_char_sequencer #(
  parameter logic [3:0] FIRST_SEL  = 4'd0,
  parameter int         MSG_LEN    = 16,
  parameter int         GAP_CYCLES = 100,
  parameter bit         APPEND_EOL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       repeat_en,
  input  logic       abort,
  output logic [3:0] mux_sel,
  input  logic [7:0] mux_data,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       busy,
  output logic       done,
  output logic [7:0] char_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [8:0] LEN = 9'(MSG_LEN);
  localparam logic [8:0] LAST_IDX =
    APPEND_EOL ? 9'(MSG_LEN + 1) : 9'(MSG_LEN - 1);
  localparam bit HAS_GAP = GAP_CYCLES > 0;
  localparam logic [15:0] GAP_LAST =
    16'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_t      state;
  state_t      nxt;
  logic [8:0]  idx;
  logic [15:0] gap_cnt;
  logic        abort_q;
  logic        abort_any;
  logic        last;
  logic        gap_end;
  logic        begin_msg;
  logic        restart;
  logic        byte_done;
  logic [8:0]  idx_nxt;

  assign abort_any = abort | abort_q;
  assign last      = idx == LAST_IDX;
  assign gap_end   = gap_cnt == GAP_LAST;
  assign begin_msg = (state == S_IDLE) && (nxt == S_LOAD);
  assign restart   = (state == S_FIN) && (nxt != S_IDLE);
  assign byte_done = (state == S_WAIT) && tx_done;
  assign idx_nxt   = idx + 9'd1;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) nxt = S_LOAD;
      end
      S_LOAD: begin
        nxt = abort_any ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (abort_any)     nxt = S_IDLE;
        else if (!tx_busy) nxt = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (last)           nxt = S_FIN;
          else if (abort_any) nxt = S_IDLE;
          else if (HAS_GAP)   nxt = S_GAP;
          else                nxt = S_LOAD;
        end
      end
      S_GAP: begin
        if (abort_any)    nxt = S_IDLE;
        else if (gap_end) nxt = S_LOAD;
      end
      S_FIN: begin
        if (repeat_en && !abort_any)
          nxt = HAS_GAP ? S_GAP : S_LOAD;
        else
          nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      abort_q  <= 1'b0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      state    <= nxt;
      tx_start <= (state == S_SEND) && (nxt == S_WAIT);
      busy     <= nxt != S_IDLE;
      done     <= nxt == S_FIN;
      gap_cnt  <= (state == S_GAP) ? gap_cnt + 16'd1 : '0;
      if (nxt == S_IDLE)
        abort_q <= 1'b0;
      else if (state != S_IDLE && abort)
        abort_q <= 1'b1;
    end
  end

  // mux_sel freezes on the last mux character while EOL bytes go out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      char_cnt <= '0;
      mux_sel  <= FIRST_SEL;
      tx_data  <= '0;
    end else begin
      if (begin_msg || restart) begin
        idx      <= '0;
        char_cnt <= '0;
        mux_sel  <= FIRST_SEL;
      end else if (byte_done) begin
        idx      <= idx_nxt;
        char_cnt <= char_cnt + 8'd1;
        if (idx_nxt < LEN) mux_sel <= mux_sel + 4'd1;
      end
      if (state == S_LOAD) begin
        if (idx < LEN)       tx_data <= mux_data;
        else if (idx == LEN) tx_data <= 8'h0D;
        else                 tx_data <= 8'h0A;
      end
    end
  end

endmodule

// File: tb/tb_uart_char_sequencer.sv
// Directed bench: wrap, EOL, gap, busy hold, abort,
// repeat and mid-message reset, against a 10-clk UART TX model.
module tb_uart_char_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       repeat_en;
  logic       abort;
  logic [3:0] mux_sel;
  logic [7:0] mux_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] char_cnt;

  logic       mbusy = 1'b0;
  logic       hold_busy;
  int         tcnt = 0;

  int         n_asserts = 0;
  int         n_fails = 0;

  int         cyc = 0;
  int         n_start = 0;
  int         n_done = 0;
  int         n_wide = 0;
  int         last_done = 0;
  logic       prev_start = 1'b0;
  logic [7:0] sent [64];
  logic [3:0] sel [64];
  int         iv [64];

  always #5 clk = ~clk;

  assign mux_data = 8'h41 + {4'h0, mux_sel};
  assign tx_busy  = mbusy | hold_busy;

  uart_char_sequencer #(
    .FIRST_SEL (4'd14),
    .MSG_LEN   (3),
    .GAP_CYCLES(3),
    .APPEND_EOL(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .repeat_en(repeat_en),
    .abort    (abort),
    .mux_sel  (mux_sel),
    .mux_data (mux_data),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .busy     (busy),
    .done     (done),
    .char_cnt (char_cnt)
  );

  // UART TX model plus monitor, both sampled on the falling edge
  always @(negedge clk) begin
    cyc        <= cyc + 1;
    prev_start <= tx_start;
    tx_done    <= 1'b0;
    if (tx_start) begin
      mbusy <= 1'b1;
      tcnt  <= 10;
      if (n_start < 64) begin
        sent[n_start] <= tx_data;
        sel[n_start]  <= mux_sel;
        iv[n_start]   <= cyc - last_done;
      end
      n_start <= n_start + 1;
      if (prev_start) n_wide <= n_wide + 1;
    end else if (mbusy) begin
      tcnt <= tcnt - 1;
      if (tcnt == 1) begin
        mbusy   <= 1'b0;
        tx_done <= 1'b1;
      end
    end
    if (tx_done) last_done <= cyc;
    if (done) n_done <= n_done + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, done}, 1);
  endtask

  task automatic wait_starts(input string tag, input int target);
    int k = 0;
    while (n_start < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, n_start, target);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, {31'd0, busy}, 0);
  endtask

  initial begin
    logic [7:0] exp_b [5];
    logic [3:0] exp_s [4];
    int b;
    int d;
    int bad;
    int k;

    exp_b = '{8'h4F, 8'h50, 8'h41, 8'h0D, 8'h0A};
    exp_s = '{4'd14, 4'd15, 4'd0, 4'd0};
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat_en = 1'b0;
    hold_busy = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_txs", {31'd0, tx_start}, 0);
    check("rst_cnt", {24'd0, char_cnt}, 0);
    check("rst_sel", {28'd0, mux_sel}, 14);
    check("rst_txd", {24'd0, tx_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full message: latency, wrap, EOL, gap spacing
    b = n_start;
    d = n_done;
    pulse_start();
    check("lat_busy", {31'd0, busy}, 1);
    check("lat_s1", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("lat_s2", {31'd0, tx_start}, 0);
    @(negedge clk);
    check("lat_s3", {31'd0, tx_start}, 1);
    check("lat_txd", {24'd0, tx_data}, 8'h4F);
    wait_done("a_done");
    check("a_cnt", {24'd0, char_cnt}, 5);
    @(negedge clk);
    check("a_done_w", {31'd0, done}, 0);
    check("a_idle", {31'd0, busy}, 0);
    check("a_nstart", n_start - b, 5);
    check("a_ndone", n_done - d, 1);
    for (int i = 0; i < 5; i++)
      check($sformatf("a_byte%0d", i), {24'd0, sent[b + i]}, {24'd0, exp_b[i]});
    for (int i = 0; i < 4; i++)
      check($sformatf("a_sel%0d", i), {28'd0, sel[b + i]}, {28'd0, exp_s[i]});
    check("a_gap", iv[b + 1], 5);

    // start together with abort in IDLE stays idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("sa_idle1", {31'd0, busy}, 0);
    @(negedge clk);
    check("sa_idle2", {31'd0, busy}, 0);

    // tx_busy held in SEND; start while busy ignored
    b = n_start;
    d = n_done;
    hold_busy = 1'b1;
    pulse_start();
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_start !== 1'b0) bad++;
      if (tx_data !== 8'h4F) bad++;
      if (busy !== 1'b1) bad++;
      @(negedge clk);
    end
    check("hold_quiet", bad, 0);
    hold_busy = 1'b0;
    @(negedge clk);
    check("hold_strobe", {31'd0, tx_start}, 1);
    check("hold_txd", {24'd0, tx_data}, 8'h4F);
    @(negedge clk);
    check("hold_1clk", {31'd0, tx_start}, 0);
    pulse_start();
    wait_done("h_done");
    @(negedge clk);
    check("h_nstart", n_start - b, 5);
    check("h_ndone", n_done - d, 1);
    wait_idle("h_idle");

    // abort during second character
    b = n_start;
    d = n_done;
    pulse_start();
    wait_starts("ab_w2", b + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_wait", {31'd0, busy}, 1);
    wait_idle("ab_idle");
    check("ab_cnt", {24'd0, char_cnt}, 2);
    repeat (30) @(negedge clk);
    check("ab_nstart", n_start - b, 2);
    check("ab_ndone", n_done - d, 0);
    pulse_start();
    repeat (2) @(negedge clk);
    check("ab_rs_txs", {31'd0, tx_start}, 1);
    check("ab_rs_txd", {24'd0, tx_data}, 8'h4F);
    check("ab_rs_sel", {28'd0, mux_sel}, 14);
    wait_done("ab_rs_done");
    @(negedge clk);

    // repeat, then reset while a strobe is high
    repeat_en = 1'b1;
    pulse_start();
    wait_done("rp_done");
    check("rp_cnt5", {24'd0, char_cnt}, 5);
    @(negedge clk);
    repeat_en = 1'b0;
    check("rp_cnt0", {24'd0, char_cnt}, 0);
    check("rp_busy", {31'd0, busy}, 1);
    check("rp_done0", {31'd0, done}, 0);
    k = 1;
    while (tx_start !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rp_gap", k, 6);
    check("rp_txd", {24'd0, tx_data}, 8'h4F);
    @(negedge clk);
    k = 0;
    while (tx_start !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("rr_txs", {31'd0, tx_start}, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rr_txs0", {31'd0, tx_start}, 0);
    check("rr_busy", {31'd0, busy}, 0);
    check("rr_done", {31'd0, done}, 0);
    check("rr_cnt", {24'd0, char_cnt}, 0);
    check("rr_sel", {28'd0, mux_sel}, 14);
    check("rr_txd", {24'd0, tx_data}, 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (2) @(negedge clk);
    check("rr_rs_txs", {31'd0, tx_start}, 1);
    check("rr_rs_txd", {24'd0, tx_data}, 8'h4F);
    wait_done("rr_rs_done");
    check("rr_rs_cnt", {24'd0, char_cnt}, 5);
    repeat (2) @(negedge clk);
    check("wide_strobe", n_wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
